layer_compositor: RTL and testbench

//  Pipelined N-layer pixel compositor between the sprite/tile ROM readers and the VGA DAC.

---
 rtl/layer_compositor.sv | 195 +++++++++++++++++++
 tb/tb_layer_compositor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage N-layer pixel compositor feeding the VGA DAC.
// Stage 1 picks the highest-priority opaque layer and the background colour.
// Stage 2 looks up the palette, or uses the background, and drives the RGB outputs.
// Optional frame-rate fade-out/fade-in: define LAYER_COMPOSITOR_FADE_EN.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned PAL_DEPTH  = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pix_valid,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [1:0]                  bg_mode,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_waddr,
  input  logic [23:0]                 pal_wdata,
  input  logic                        fade_start,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic                        fade_busy
);

  localparam int unsigned AW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;

  logic [23:0]      palette [PAL_DEPTH];

  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [23:0]      bg_rgb;

  logic             s1_valid;
  logic             s1_hit;
  logic [IDX_W-1:0] s1_idx;
  logic [23:0]      s1_bg;

  logic [23:0]      src_rgb;
  logic [23:0]      shaded_rgb;

  // Priority search: the lowest-numbered layer with an in-range, non-zero index wins
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      cand = layer_idx[k*IDX_W +: IDX_W];
      if (!win_hit && layer_en[k] && (cand != '0) && (32'(cand) < PAL_DEPTH)) begin
        win_hit = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Background colour for the current pixel
  always_comb begin
    case (bg_mode)
      2'd0:    bg_rgb = {8'h3F, 8'h00, 8'h7F - 8'(DrawX >> 3)};
      2'd1:    bg_rgb = 24'h228B22;
      2'd2:    bg_rgb = 24'h6666B2;
      default: bg_rgb = 24'hB22222;
    endcase
  end

  // Stage 1 register: winner, background and valid bit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= win_hit;
      s1_idx   <= win_idx;
      s1_bg    <= bg_rgb;
    end
  end

  // Palette RAM write port; contents survive Reset
  always_ff @(posedge Clk) begin
    if (pal_we && (32'(pal_waddr) < PAL_DEPTH)) begin
      palette[pal_waddr[AW-1:0]] <= pal_wdata;
    end
  end

  // Source colour for stage 2; a write on the same edge is not yet visible here
  always_comb begin
    src_rgb = s1_hit ? palette[s1_idx[AW-1:0]] : s1_bg;
  end

`ifdef LAYER_COMPOSITOR_FADE_EN
  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    HOLD,
    FADE_IN
  } fade_state_t;

  fade_state_t state;
  logic [3:0]  level;
  logic        frame_tick;

  assign frame_tick = pix_valid && (DrawX == 10'd0) && (DrawY == 10'd0);

  function automatic logic [7:0] apply_gain(input logic [7:0] c, input logic [3:0] lv);
    logic [11:0] prod;
    prod = {4'b0, c} * {7'b0, ({1'b0, lv} + 5'd1)};
    return 8'(prod >> 4);
  endfunction

  // Fade sequencer: every frame tick either steps the level or advances the state.
  // FADE_OUT spends one extra tick at level 0 before HOLD; FADE_IN leaves on the
  // tick that lands on 15, so a full sequence spans 32 ticks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      level     <= 4'd15;
      fade_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fade_start) begin
            state     <= FADE_OUT;
            fade_busy <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (level == 4'd0) state <= HOLD;
            else               level <= level - 4'd1;
          end
        end
        HOLD: begin
          if (frame_tick) state <= FADE_IN;
        end
        FADE_IN: begin
          if (frame_tick) begin
            level <= level + 4'd1;
            if (level == 4'd14) begin
              state     <= IDLE;
              fade_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          level     <= 4'd15;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel gain (level+1)/16
  always_comb begin
    shaded_rgb = {apply_gain(src_rgb[23:16], level),
                  apply_gain(src_rgb[15:8],  level),
                  apply_gain(src_rgb[7:0],   level)};
  end
`else
  logic unused_fade;

  assign fade_busy   = 1'b0;
  assign unused_fade = ^{fade_start, DrawY};

  // No fade: unity gain
  always_comb begin
    shaded_rgb = src_rgb;
  end
`endif

  // Stage 2 register: RGB out, blanked on bubbles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        {VGA_R, VGA_G, VGA_B} <= shaded_rgb;
      end else begin
        {VGA_R, VGA_G, VGA_B} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed corner cases plus a randomized stream
// compared against a reference model of the compositing rules.
module tb_layer_compositor;

  localparam int unsigned NL = 4;
  localparam int unsigned IW = 5;
  localparam int unsigned PD = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             pix_valid;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [NL-1:0]    layer_en;
  logic [NL*IW-1:0] layer_idx;
  logic [1:0]       bg_mode;
  logic             pal_we;
  logic [IW-1:0]    pal_waddr;
  logic [23:0]      pal_wdata;
  logic             fade_start;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;
  logic             out_valid;
  logic             fade_busy;

  layer_compositor #(
    .NUM_LAYERS(NL),
    .IDX_W     (IW),
    .PAL_DEPTH (PD)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .pix_valid (pix_valid),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .layer_en  (layer_en),
    .layer_idx (layer_idx),
    .bg_mode   (bg_mode),
    .pal_we    (pal_we),
    .pal_waddr (pal_waddr),
    .pal_wdata (pal_wdata),
    .fade_start(fade_start),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .out_valid (out_valid),
    .fade_busy (fade_busy)
  );

  always #5 Clk = ~Clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state: palette contents and the pixel waiting for its lookup
  logic [23:0]      mpal [PD];
  logic             pv_valid = 1'b0;
  logic [NL-1:0]    pv_en;
  logic [NL*IW-1:0] pv_idx;
  logic [1:0]       pv_mode;
  logic [9:0]       pv_x;
  logic             e_valid;
  logic [23:0]      e_rgb;
  bit               model_on = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NL*IW-1:0] pack(input logic [IW-1:0] a0, input logic [IW-1:0] a1,
                                            input logic [IW-1:0] a2, input logic [IW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [23:0] ref_colour(input logic [NL-1:0] en, input logic [NL*IW-1:0] idx,
                                             input logic [1:0] mode, input logic [9:0] x);
    int unsigned v;
    int          hit;
    int unsigned b;
    hit = -1;
    for (int k = 0; k < int'(NL); k++) begin
      v = (idx >> (IW * k)) & ((1 << IW) - 1);
      if (hit < 0 && en[k] && v != 0 && v < PD) hit = int'(v);
    end
    if (hit >= 0) return mpal[hit];
    b = (127 - int'(x) / 8) & 255;
    case (mode)
      2'd0:    return {8'h3F, 8'h00, 8'(b)};
      2'd1:    return 24'h228B22;
      2'd2:    return 24'h6666B2;
      default: return 24'hB22222;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [NL-1:0] en, input logic [NL*IW-1:0] idx,
                       input logic [1:0] mode, input logic [9:0] x, input logic [9:0] y);
    pix_valid = v;
    layer_en  = en;
    layer_idx = idx;
    bg_mode   = mode;
    DrawX     = x;
    DrawY     = y;
  endtask

  // One clock: advance the reference pipeline, then compare outputs 1 ns after the edge
  task automatic cycle();
    @(posedge Clk);
    if (Reset) begin
      e_valid  = 1'b0;
      e_rgb    = 24'h0;
      pv_valid = 1'b0;
    end else begin
      e_valid  = pv_valid;
      e_rgb    = pv_valid ? ref_colour(pv_en, pv_idx, pv_mode, pv_x) : 24'h0;
      pv_valid = pix_valid;
      pv_en    = layer_en;
      pv_idx   = layer_idx;
      pv_mode  = bg_mode;
      pv_x     = DrawX;
    end
    if (pal_we && pal_waddr < PD) mpal[pal_waddr] = pal_wdata;
    #1;
    if (model_on) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
      check("rgb", {8'b0, VGA_R, VGA_G, VGA_B}, {8'b0, e_rgb});
      check("fade_busy", {31'b0, fade_busy}, 32'd0);
    end
  endtask

  initial begin
    Reset      = 1'b1;
    pal_we     = 1'b0;
    pal_waddr  = '0;
    pal_wdata  = '0;
    fade_start = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0);

    // Reset held 3 cycles
    repeat (3) cycle();
    check("reset_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, fade_busy}, 32'd0);
    Reset = 1'b0;

    // Fill the palette
    for (int i = 0; i < int'(PD); i++) begin
      pal_we    = 1'b1;
      pal_waddr = IW'(i);
      pal_wdata = 24'($urandom);
      cycle();
    end
    pal_waddr = 5'd3; pal_wdata = 24'h123456; cycle();
    pal_waddr = 5'd5; pal_wdata = 24'h0A0B0C; cycle();
    pal_we = 1'b0;

    // Layer 1 beats layer 2
    drive(1'b1, 4'b0110, pack(5'd0, 5'd3, 5'd7, 5'd0), 2'd0, 10'd5, 10'd1); cycle();
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0); cycle();
    check("t2_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h123456);
    check("t2_valid", {31'b0, out_valid}, 32'd1);

    // All transparent: gradient then mode 3
    drive(1'b1, 4'b1111, '0, 2'd0, 10'd80, 10'd0); cycle();
    drive(1'b1, 4'b1111, '0, 2'd3, 10'd80, 10'd0); cycle();
    check("t3_grad", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h3F0075);
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0); cycle();
    check("t3_mode3", {8'b0, VGA_R, VGA_G, VGA_B}, 32'hB22222);

    // Palette read/write collision returns old data
    drive(1'b1, 4'b0001, pack(5'd5, 5'd0, 5'd0, 5'd0), 2'd1, 10'd0, 10'd2); cycle();
    pal_we = 1'b1; pal_waddr = 5'd5; pal_wdata = 24'hFFFFFF; cycle();
    check("t4_old", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0A0B0C);
    pal_we = 1'b0;
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0); cycle();
    check("t4_new", {8'b0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);

    // Bubble pattern 1,0,1
    drive(1'b1, 4'b0000, '0, 2'd1, 10'd9, 10'd3); cycle();
    drive(1'b0, 4'b0000, '0, 2'd1, 10'd9, 10'd3); cycle();
    check("t5_v1", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 4'b0000, '0, 2'd2, 10'd9, 10'd3); cycle();
    check("t5_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("t5_bubble_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0);
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0); cycle();
    check("t5_v3", {31'b0, out_valid}, 32'd1);
    check("t5_rgb3", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h6666B2);

    // Reset mid-stream flushes the pipeline
    drive(1'b1, 4'b0001, pack(5'd3, 5'd0, 5'd0, 5'd0), 2'd0, 10'd7, 10'd7); cycle();
    Reset = 1'b1; cycle(); cycle();
    check("rst_flush", {31'b0, out_valid}, 32'd0);
    Reset = 1'b0; cycle();
    check("rst_lat1", {31'b0, out_valid}, 32'd0);
    cycle();
    check("rst_lat2", {31'b0, out_valid}, 32'd1);
    check("rst_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h123456);

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      Reset     = ($urandom_range(0, 63) == 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      layer_en  = NL'($urandom);
      for (int k = 0; k < int'(NL); k++)
        layer_idx[k*IW +: IW] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
      bg_mode   = 2'($urandom);
      DrawX     = 10'($urandom);
      DrawY     = 10'($urandom);
      pal_we    = ($urandom_range(0, 7) == 0);
      pal_waddr = IW'($urandom);
      pal_wdata = 24'($urandom);
`ifdef LAYER_COMPOSITOR_FADE_EN
      fade_start = 1'b0;
`else
      fade_start = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end
    Reset      = 1'b0;
    pal_we     = 1'b0;
    fade_start = 1'b0;

`ifdef LAYER_COMPOSITOR_FADE_EN
    // Fade sequence on a constant F0F0F0 pixel, four pixels per frame
    model_on   = 1'b0;
    pal_we     = 1'b1; pal_waddr = 5'd9; pal_wdata = 24'hF0F0F0;
    fade_start = 1'b1;
    drive(1'b1, 4'b0001, pack(5'd9, 5'd0, 5'd0, 5'd0), 2'd0, 10'd1, 10'd0); cycle();
    pal_we     = 1'b0;
    fade_start = 1'b0;
    for (int f = 1; f <= 32; f++) begin
      drive(1'b1, 4'b0001, pack(5'd9, 5'd0, 5'd0, 5'd0), 2'd0, 10'd0, 10'd0); cycle();
      repeat (3) begin
        drive(1'b1, 4'b0001, pack(5'd9, 5'd0, 5'd0, 5'd0), 2'd0, 10'd1, 10'd0); cycle();
      end
      if (f == 8)  check("fade_mid", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h787878);
      if (f == 15) begin
        check("fade_min", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h0F0F0F);
        check("fade_busy_min", {31'b0, fade_busy}, 32'd1);
      end
      if (f == 31) check("fade_busy_31", {31'b0, fade_busy}, 32'd1);
      if (f == 32) begin
        check("fade_done_busy", {31'b0, fade_busy}, 32'd0);
        check("fade_done_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'hF0F0F0);
      end
    end
    model_on = 1'b1;
    drive(1'b0, '0, '0, 2'd0, 10'd0, 10'd0);
    repeat (3) cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
